// File: rtl/riscv_retire_monitor_pkg.sv
// Shared encodings for the retire monitor: retire kinds, halt FSM states, default halt words.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package riscv_retire_monitor_pkg;

   // Retire kind encodings carried on RET_KIND
   localparam logic [1:0] KIND_RF   = 2'd0;   // register write, value is RF_WD
   localparam logic [1:0] KIND_ST   = 2'd1;   // store, value is store address
   localparam logic [1:0] KIND_BR   = 2'd2;   // branch, value is {31'b0, taken}
   localparam logic [1:0] KIND_NONE = 2'd3;   // no observable output (e.g. write to x0)

   // Default halt sequence: addi x1,x0,12 followed directly by jalr x0,0(x1)
   localparam logic [31:0] DEF_HALT_INST0 = 32'h00c0_0093;
   localparam logic [31:0] DEF_HALT_INST1 = 32'h0000_8067;

   // Halt detector states
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_ARMED  = 2'd1,
      ST_HALTED = 2'd2
   } halt_state_t;

   // True when a retire of this kind publishes a checkpoint value
   function automatic logic kind_has_output(input logic [1:0] kind);
      logic has_out;
      case (kind)
         KIND_RF, KIND_ST, KIND_BR: has_out = 1'b1;
         KIND_NONE:                 has_out = 1'b0;
         default:                   has_out = 1'b0;
      endcase
      return has_out;
   endfunction

endpackage

// File: rtl/riscv_halt_detect.sv
// Halt-sequence detector: watches accepted retires for HALT_INST0 immediately followed by HALT_INST1.
// Latency: halt registered at the edge accepting HALT_INST1; ret_ready decodes state combinationally.
// Backpressure: ret_ready drops once halted and stays low until RST.
module riscv_halt_detect
   import riscv_retire_monitor_pkg::*;
#(
   parameter logic [31:0] HALT_INST0 = DEF_HALT_INST0,
   parameter logic [31:0] HALT_INST1 = DEF_HALT_INST1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ret_acc,
   input  logic [31:0] ret_inst,
   output logic        halt,
   output logic        ret_ready
);

   halt_state_t state;

   // Halt FSM; idle cycles in ARMED keep the partial sequence alive
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_RUN;
         halt  <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (ret_acc && (ret_inst == HALT_INST0)) begin
                  state <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (ret_acc) begin
                  if (ret_inst == HALT_INST1) begin
                     state <= ST_HALTED;
                     halt  <= 1'b1;
                  end else if (ret_inst == HALT_INST0) begin
                     state <= ST_ARMED;
                  end else begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_HALTED: begin
               halt <= 1'b1;
            end
            default: begin
               state <= ST_RUN;
               halt  <= 1'b0;
            end
         endcase
      end
   end

   // Retires are refused only after the halt sequence completes
   always_comb begin
      ret_ready = (state != ST_HALTED);
   end

endmodule

// File: rtl/riscv_retire_monitor.sv
// Retire monitor: counts retired instructions, publishes the checkpoint value, flags the halt sequence.
// Latency: NUM_INST/OUTPUT_PORT/HALT update at the edge that accepts the retire (visible next cycle).
// Backpressure: RET_READY low once halted; retires offered then are dropped without effect.
module riscv_retire_monitor
   import riscv_retire_monitor_pkg::*;
#(
   parameter logic [31:0] HALT_INST0 = DEF_HALT_INST0,
   parameter logic [31:0] HALT_INST1 = DEF_HALT_INST1,
   parameter int          CNT_W      = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             RET_VALID,
   input  logic [31:0]      RET_INST,
   input  logic [1:0]       RET_KIND,
   input  logic [31:0]      RET_VAL,
   output logic             RET_READY,
   output logic [CNT_W-1:0] NUM_INST,
   output logic [31:0]      OUTPUT_PORT,
   output logic             HALT
);

   logic ret_acc;

   // A retire counts only when offered while the monitor is still running
   always_comb begin
      ret_acc = RET_VALID & RET_READY;
   end

   riscv_halt_detect #(
      .HALT_INST0 (HALT_INST0),
      .HALT_INST1 (HALT_INST1)
   ) u_halt_detect (
      .CLK       (CLK),
      .RST       (RST),
      .ret_acc   (ret_acc),
      .ret_inst  (RET_INST),
      .halt      (HALT),
      .ret_ready (RET_READY)
   );

   // Count and checkpoint value move on the same edge so the consumer sees a consistent pair
   always_ff @(posedge CLK) begin
      if (RST) begin
         NUM_INST    <= '0;
         OUTPUT_PORT <= '0;
      end else if (ret_acc) begin
         if (NUM_INST != {CNT_W{1'b1}}) begin
            NUM_INST <= NUM_INST + CNT_W'(1);
         end
         if (kind_has_output(RET_KIND)) begin
            OUTPUT_PORT <= RET_VAL;
         end
      end
   end

endmodule

// File: tb/tb_riscv_retire_monitor.sv
// Bench for riscv_retire_monitor: table-driven retire stream with a scoreboard queue, plus a saturation sequence.
// Latency: each vector is driven at a falling edge and its expected result popped at the next falling edge.
// Backpressure: halted-state vectors check that offered retires are dropped.
module tb_riscv_retire_monitor;

   localparam logic [31:0] H0   = 32'h00c0_0093;
   localparam logic [31:0] H1   = 32'h0000_8067;
   localparam logic [31:0] ADDI = 32'h0010_0113;
   localparam logic [31:0] OTH  = 32'h0000_0013;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RST;
   logic        RET_VALID;
   logic [31:0] RET_INST;
   logic [1:0]  RET_KIND;
   logic [31:0] RET_VAL;
   logic        RET_READY;
   logic [31:0] NUM_INST;
   logic [31:0] OUTPUT_PORT;
   logic        HALT;

   logic        rdy_s;
   logic [3:0]  num_s;
   logic [31:0] out_s;
   logic        halt_s;

   riscv_retire_monitor dut (
      .CLK         (CLK),
      .RST         (RST),
      .RET_VALID   (RET_VALID),
      .RET_INST    (RET_INST),
      .RET_KIND    (RET_KIND),
      .RET_VAL     (RET_VAL),
      .RET_READY   (RET_READY),
      .NUM_INST    (NUM_INST),
      .OUTPUT_PORT (OUTPUT_PORT),
      .HALT        (HALT)
   );

   // Narrow-counter instance sharing the same stimulus, used for the saturation corner
   riscv_retire_monitor #(.CNT_W(4)) dut_s (
      .CLK         (CLK),
      .RST         (RST),
      .RET_VALID   (RET_VALID),
      .RET_INST    (RET_INST),
      .RET_KIND    (RET_KIND),
      .RET_VAL     (RET_VAL),
      .RET_READY   (rdy_s),
      .NUM_INST    (num_s),
      .OUTPUT_PORT (out_s),
      .HALT        (halt_s)
   );

   typedef struct {
      logic        rst;
      logic        vld;
      logic [31:0] inst;
      logic [1:0]  kind;
      logic [31:0] val;
      logic [31:0] num;
      logic [31:0] outp;
      logic [31:0] halt;
      logic [31:0] rdy;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] num;
      logic [31:0] outp;
      logic [31:0] halt;
      logic [31:0] rdy;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic vld, input logic [31:0] inst,
                      input logic [1:0] kind, input logic [31:0] val,
                      input logic [31:0] num, input logic [31:0] outp,
                      input logic [31:0] halt, input logic [31:0] rdy);
      vec_t v;
      v.rst = rst; v.vld = vld; v.inst = inst; v.kind = kind; v.val = val;
      v.num = num; v.outp = outp; v.halt = halt; v.rdy = rdy;
      vecs.push_back(v);
   endtask

   // Runaway guard: the whole run is a few hundred cycles
   initial begin
      #20000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      RST = 1'b1; RET_VALID = 1'b0; RET_INST = '0; RET_KIND = '0; RET_VAL = '0;

      //   rst  vld inst  kind val          num outp        halt rdy
      // reset, two cycles
      add(1'b1, 1'b0, OTH,  2'd0, 32'h0,      0, 32'h0,      0, 1);
      add(1'b1, 1'b0, OTH,  2'd0, 32'h0,      0, 32'h0,      0, 1);
      // reg write, store, no-output
      add(1'b0, 1'b1, OTH,  2'd0, 32'h0eec,   1, 32'h0eec,   0, 1);
      add(1'b0, 1'b1, OTH,  2'd1, 32'h0ed8,   2, 32'h0ed8,   0, 1);
      add(1'b0, 1'b1, OTH,  2'd3, 32'hdead,   3, 32'h0ed8,   0, 1);
      // five idle cycles with garbage on the data lines
      for (int i = 0; i < 5; i++)
         add(1'b0, 1'b0, OTH, 2'd0, 32'h1234,  3, 32'h0ed8,   0, 1);
      // branch taken
      add(1'b0, 1'b1, OTH,  2'd2, 32'h1,      4, 32'h1,      0, 1);
      // reset mid-stream overrides a valid retire
      add(1'b1, 1'b1, OTH,  2'd0, 32'h7777,   0, 32'h0,      0, 1);
      add(1'b1, 1'b0, OTH,  2'd0, 32'h0,      0, 32'h0,      0, 1);
      add(1'b0, 1'b1, OTH,  2'd0, 32'h55,     1, 32'h55,     0, 1);
      // halt sequence with an idle cycle (HALT_INST1 on the bus but not valid)
      add(1'b0, 1'b1, H0,   2'd0, 32'hc,      2, 32'hc,      0, 1);
      add(1'b0, 1'b0, H1,   2'd3, 32'h0,      2, 32'hc,      0, 1);
      add(1'b0, 1'b1, H1,   2'd3, 32'h0,      3, 32'hc,      1, 0);
      // halted: offered retires are dropped
      add(1'b0, 1'b1, OTH,  2'd0, 32'h999,    3, 32'hc,      1, 0);
      add(1'b0, 1'b1, H0,   2'd0, 32'h7,      3, 32'hc,      1, 0);
      // reset while halted
      add(1'b1, 1'b0, OTH,  2'd0, 32'h0,      0, 32'h0,      0, 1);
      // broken sequence: H0, addi, H1 -> no halt
      add(1'b0, 1'b1, H0,   2'd0, 32'hc,      1, 32'hc,      0, 1);
      add(1'b0, 1'b1, ADDI, 2'd0, 32'h22,     2, 32'h22,     0, 1);
      add(1'b0, 1'b1, H1,   2'd3, 32'h0,      3, 32'h22,     0, 1);
      // repeated H0 keeps the sequence armed
      add(1'b0, 1'b1, H0,   2'd0, 32'hc,      4, 32'hc,      0, 1);
      add(1'b0, 1'b1, H0,   2'd0, 32'hc,      5, 32'hc,      0, 1);
      add(1'b0, 1'b1, H1,   2'd3, 32'h0,      6, 32'hc,      1, 0);
      add(1'b1, 1'b0, OTH,  2'd0, 32'h0,      0, 32'h0,      0, 1);
      // reset while armed discards the partial sequence
      add(1'b0, 1'b1, H0,   2'd0, 32'hc,      1, 32'hc,      0, 1);
      add(1'b1, 1'b0, OTH,  2'd0, 32'h0,      0, 32'h0,      0, 1);
      add(1'b0, 1'b1, H1,   2'd3, 32'h0,      1, 32'h0,      0, 1);

      foreach (vecs[i]) begin
         RST       = vecs[i].rst;
         RET_VALID = vecs[i].vld;
         RET_INST  = vecs[i].inst;
         RET_KIND  = vecs[i].kind;
         RET_VAL   = vecs[i].val;
         e.idx = i; e.num = vecs[i].num; e.outp = vecs[i].outp;
         e.halt = vecs[i].halt; e.rdy = vecs[i].rdy;
         exp_q.push_back(e);
         @(negedge CLK);
         e = exp_q.pop_front();
         chk($sformatf("v%0d NUM_INST", e.idx),    NUM_INST,          e.num);
         chk($sformatf("v%0d OUTPUT_PORT", e.idx), OUTPUT_PORT,       e.outp);
         chk($sformatf("v%0d HALT", e.idx),        32'(HALT),         e.halt);
         chk($sformatf("v%0d RET_READY", e.idx),   32'(RET_READY),    e.rdy);
      end

      // Saturation on the 4-bit instance: 15 retires reach all-ones, further retires hold it
      RST = 1'b1; RET_VALID = 1'b0; RET_INST = OTH; RET_KIND = 2'd3; RET_VAL = 32'h0;
      @(negedge CLK);
      chk("sat reset num_s", 32'(num_s), 32'h0);
      RST = 1'b0;
      RET_VALID = 1'b1;
      for (int i = 0; i < 15; i++) @(negedge CLK);
      chk("sat 15 num_s", 32'(num_s), 32'hf);
      chk("sat 15 NUM_INST", NUM_INST, 32'd15);
      RET_KIND = 2'd0; RET_VAL = 32'habc;
      @(negedge CLK);
      chk("sat 16 num_s", 32'(num_s), 32'hf);
      chk("sat 16 out_s", out_s, 32'habc);
      chk("sat 16 NUM_INST", NUM_INST, 32'd16);
      RET_KIND = 2'd3;
      @(negedge CLK);
      chk("sat 17 num_s", 32'(num_s), 32'hf);
      chk("sat 17 rdy_s", 32'(rdy_s), 32'h1);
      RET_VALID = 1'b0;
      @(negedge CLK);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
